// File: rtl/serial_adder_if.sv
// ============================================================================
//  Module      : serial_adder_if
//  Description : Operand/result handshake bundle for serial_adder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, b, cin, in_valid, out_ready,
        input  in_ready, s, cout, ovf, out_valid
    );

    modport slave (
        input  a, b, cin, in_valid, out_ready,
        output in_ready, s, cout, ovf, out_valid
    );
endinterface

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
//  Module      : serial_adder
//  Description : Digit-serial adder, DIGIT bits per clock, with carry-out and
//                signed overflow, valid/ready handshake on both sides.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  wire           clk,
    input  wire           rst,
    serial_adder_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;
    logic             w_in_ready;
    logic             w_last;
    logic [DIGIT:0]   w_digit_sum;
    logic             w_c_msb;
    logic [WIDTH-1:0] w_sum_next;

    assign w_last      = (r_cnt == CW'(N - 1));
    assign w_digit_sum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                       + {{DIGIT{1'b0}}, r_carry};
    // Carry into the digit MSB recovered from its sum bit and operand bits.
    assign w_c_msb     = w_digit_sum[DIGIT-1] ^ r_a[DIGIT-1] ^ r_b[DIGIT-1];
    assign w_sum_next  = (r_sum >> DIGIT)
                       | (WIDTH'(w_digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        if (!rst && (r_state == S_IDLE)) begin
            w_in_ready = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_s         <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.cin;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_digit_sum[DIGIT];
                    r_sum   <= w_sum_next;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_s         <= w_sum_next;
                        r_cout      <= w_digit_sum[DIGIT];
                        r_ovf       <= w_c_msb ^ w_digit_sum[DIGIT];
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.s         = r_s;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;
    assign bus.out_valid = r_out_valid;

endmodule

`default_nettype wire
